demux_1xn_stream: RTL

DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

---
 rtl/demux_pkg.sv | 7 +
 rtl/demux_ch_counter.sv | 15 +
 rtl/demux_1xn_stream.sv | 64 ++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared state type, counter width and default sizing for the stream demux
package demux_pkg;
    typedef enum logic {EMPTY, FULL} state_t;
    localparam int DEMUX_CNT_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 8;
endpackage

// File: rtl/demux_ch_counter.sv
// demux_ch_counter: wrapping per-channel output-transfer counter
module demux_ch_counter
    import demux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    output logic [DEMUX_CNT_W-1:0] count
);
    // count transfers, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (inc) count <= count + 1'b1;
    end
endmodule

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: one-entry registered 1-to-N stream demux; DEMUX_STATS_EN adds per-channel transfer counters
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_drop
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH-1:0][DEMUX_CNT_W-1:0] ch_count
`endif
);
    state_t            state;
    logic [DATA_W-1:0] hold_data;
    logic [SEL_W-1:0]  hold_sel;
    logic              in_xfer;
    logic              out_xfer;
    logic              legal;
    assign out_xfer  = (state == FULL) && out_ready[hold_sel];
    assign in_ready  = (state == EMPTY) || out_ready[hold_sel];
    assign in_xfer   = in_valid && in_ready;
    assign legal     = int'(in_sel) < NUM_CH;
    assign out_data  = hold_data;
    assign out_valid = (state == FULL) ? {{(NUM_CH-1){1'b0}}, 1'b1} << hold_sel : '0;
    // single-entry slot: a legal accepted beat always loads, otherwise a departing beat empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            hold_data <= '0;
            hold_sel  <= '0;
            err_drop  <= 1'b0;
        end else begin
            err_drop <= in_xfer && !legal;
            if (in_xfer && legal) begin
                state     <= FULL;
                hold_data <= in_data;
                hold_sel  <= in_sel;
            end else if (out_xfer) begin
                state <= EMPTY;
            end
        end
    end
`ifdef DEMUX_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        demux_ch_counter u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (out_xfer && (hold_sel == SEL_W'(i))),
            .count (ch_count[i])
        );
    end
`endif
endmodule
